// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: default widths,
// RAM access direction codes and the read-sequencer state encoding.
package ram_fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;

    localparam logic RAM_WRITE = 1'b0;
    localparam logic RAM_READ  = 1'b1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port 1-cycle-latency RAM. Reads take
// priority on the port; the head word is held in a one-word output register.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     mem_count_q, mem_count_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic rd_issue;
    logic wr_accept;
    logic pop;
    logic full_w;
    logic wr_ready_w;

    always_comb begin
        full_w     = (mem_count_q == DEPTH);
        rd_issue   = (state_q == S_IDLE) && (mem_count_q != '0) &&
                     (!out_valid_q || rd_ready);
        wr_ready_w = !reset && !full_w && !rd_issue;
        wr_accept  = wr_valid && wr_ready_w;
        pop        = out_valid_q && rd_ready;
    end

    // One RAM access per cycle; the idle default is a harmless read so the
    // RAM is never written unless a push is actually accepted.
    always_comb begin
        ram_rw      = RAM_READ;
        ram_address = rd_ptr_q;
        ram_data_in = '0;
        if (rd_issue) begin
            ram_rw      = RAM_READ;
            ram_address = rd_ptr_q;
        end else if (wr_accept) begin
            ram_rw      = RAM_WRITE;
            ram_address = wr_ptr_q;
            ram_data_in = wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // rd_issue and wr_accept are mutually exclusive, so the count moves by at most one.
        if (rd_issue) begin
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            mem_count_d = mem_count_q - (ADDR_W+1)'(1);
            state_d     = S_RD_WAIT;
        end else if (wr_accept) begin
            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
            mem_count_d = mem_count_q + (ADDR_W+1)'(1);
        end

        if (state_q == S_RD_WAIT) begin
            out_data_d  = ram_data_out;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign wr_ready = wr_ready_w;
    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
    assign count    = mem_count_q;
    assign full     = full_w;
    assign empty    = (mem_count_q == '0) && !out_valid_q && (state_q == S_IDLE);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural 1024x16 single-port RAM
// (registered read, one cycle latency) attached to the RAM port.
module tb_ram_fifo_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic [10:0] count;
    logic        full;
    logic        empty;
    logic [9:0]  ram_address;
    logic [15:0] ram_data_in;
    logic        ram_rw;
    logic [15:0] ram_data_out;

    logic [15:0] mem [1024];

    int checks = 0;
    int errors = 0;

    ram_fifo_ctrl #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_rw(ram_rw), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rw == 1'b0) mem[ram_address] <= ram_data_in;
        else                ram_data_out     <= mem[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are changed 1 time unit after an edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int k, input logic [15:0] base);
        int n = 0;
        int cyc = 0;
        rd_ready = 1'b0;
        while (n < k && cyc < 4 * k + 20) begin
            wr_valid = 1'b1;
            wr_data  = base + 16'(n);
            #1;
            if (wr_ready) n++;
            step();
            cyc++;
        end
        wr_valid = 1'b0;
        chk("push_accepted", n, k);
    endtask

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic        rr;
        logic        e_rv;
        logic [15:0] e_rd;
        logic [10:0] e_cnt;
        logic        e_empty;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int got;
        int cyc;
        int pushed;
        int popped;
        logic [9:0] exp_waddr;

        vecs[0] = '{1'b1, 16'd5, 1'b0, 1'b0, 16'd0, 11'd1, 1'b0}; // 5 written at addr 0
        vecs[1] = '{1'b1, 16'd9, 1'b0, 1'b0, 16'd0, 11'd0, 1'b0}; // read issue stalls the push
        vecs[2] = '{1'b1, 16'd9, 1'b0, 1'b1, 16'd5, 11'd1, 1'b0}; // 9 written in RD_WAIT
        vecs[3] = '{1'b0, 16'd0, 1'b0, 1'b1, 16'd5, 11'd1, 1'b0};
        vecs[4] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd5, 11'd0, 1'b0}; // pop 5 + issue
        vecs[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd9, 11'd0, 1'b0};
        vecs[6] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd9, 11'd0, 1'b1}; // pop 9
        vecs[7] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd9, 11'd0, 1'b1}; // empty pop ignored

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        step();
        chk("wr_ready_in_reset", wr_ready, 0);
        step();
        reset = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_rw", ram_rw, 1);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_data_in", ram_data_in, 0);
        chk("rst_full", full, 0);
        chk("rst_wr_ready", wr_ready, 1);

        for (int i = 0; i < 8; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_ready = vecs[i].rr;
            step();
            chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].e_rv);
            chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rd);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
        end
        chk("mem0_is_5", mem[0], 5);
        chk("mem1_is_9", mem[1], 9);
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Fill: head word moves to the output register, so 1025 pushes fit.
        push_n(1025, 16'd0);
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        #1;
        chk("fill_wr_ready", wr_ready, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 1024);
        step(); step(); step();
        chk("over_count", count, 1024);
        chk("over_full", full, 1);
        chk("over_head_valid", rd_valid, 1);
        chk("over_head_data", rd_data, 0);
        wr_valid = 1'b0;

        got = 0;
        cyc = 0;
        rd_ready = 1'b1;
        while (got < 1025 && cyc < 3000) begin
            #1;
            if (rd_valid) begin
                checks++;
                if (rd_data !== 16'(got)) begin
                    errors++;
                    $display("FAIL drain_word %0d: got 0x%0h expected 0x%0h", got, rd_data, 16'(got));
                end
                got++;
            end
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        chk("drain_total", got, 1025);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Stream: write pointer is 2 (table) + 1025 (fill) = 1027 -> 3 after wrap.
        exp_waddr = 10'd3;
        pushed = 0;
        popped = 0;
        cyc = 0;
        rd_ready = 1'b1;
        while (popped < 20 && cyc < 200) begin
            wr_valid = (pushed < 20);
            wr_data  = 16'd100 + 16'(pushed);
            #1;
            if (wr_valid && wr_ready) begin
                chk("stream_wr_rw", ram_rw, 0);
                chk("stream_wr_addr", ram_address, exp_waddr);
                chk("stream_wr_data", ram_data_in, 16'd100 + 16'(pushed));
                exp_waddr = exp_waddr + 10'd1;
                pushed++;
            end else begin
                chk("stream_rd_rw", ram_rw, 1);
            end
            if (rd_valid && rd_ready) begin
                chk("stream_pop_data", rd_data, 16'd100 + 16'(popped));
                popped++;
            end
            step();
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("stream_popped", popped, 20);
        chk("stream_cycles_le_42", (cyc <= 42), 1);
        chk("stream_empty", empty, 1);

        // Reset while a read is in flight with three words held.
        push_n(4, 16'h00A1);
        rd_ready = 1'b1;
        #1;
        chk("mid_head_valid", rd_valid, 1);
        chk("mid_head_data", rd_data, 16'h00A1);
        step();
        rd_ready = 1'b0;
        chk("mid_count", count, 2);
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_empty", empty, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_empty", empty, 1);
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_rd_data", rd_data, 0);

        push_n(1, 16'h0077);
        cyc = 0;
        while (!rd_valid && cyc < 10) begin
            step();
            cyc++;
        end
        chk("post_rst_valid", rd_valid, 1);
        chk("post_rst_word", rd_data, 16'h0077);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("post_rst_final_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
